stopwatch_ctrl: RTL

Controller that sequences and displays the mod-60 seconds counter on the two-digit 7-segment board. It generates the counter's count-enable tick from the system clock and turns start/stop and clear buttons into a RUN/PAUSE/IDLE state machine with clear pulses. It time-multiplexes the counter's `tens`/`digits` BCD outputs onto one shared BCD-to-7-segment decoder with active-low digit anodes. It sits between the board buttons, the counter and the segment decoder.

---
 rtl/stopwatch_ctrl_if.sv | 31 +++
 rtl/stopwatch_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl_if.sv
// Counter/display-side bundle of the stopwatch controller: counter digits in,
// count tick/clear out, shared segment-decoder value and digit anodes out.
interface stopwatch_ctrl_if;
  logic [3:0] tens;
  logic [3:0] digits;
  logic       cnt_en;
  logic       cnt_clr;
  logic [3:0] seg_bcd;
  logic [1:0] an;
  logic       running;

  modport master (
    input  tens,
    input  digits,
    output cnt_en,
    output cnt_clr,
    output seg_bcd,
    output an,
    output running
  );

  modport slave (
    output tens,
    output digits,
    input  cnt_en,
    input  cnt_clr,
    input  seg_bcd,
    input  an,
    input  running
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: button sync/edge detect, IDLE/RUN/PAUSE FSM, tick prescaler
// and two-digit display multiplexer. Optional leading-zero blanking: STOPWATCH_BLANK_EN.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 50_000_000,
  parameter int SCAN_DIV = 100_000
) (
  input  logic              Clk,
  input  logic              RST_n,
  input  logic              btn_ss,
  input  logic              btn_clr,
  stopwatch_ctrl_if.master  bus
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRE_ONE  = PW'(1);
  localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] SCAN_ONE = SW'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    PAUSE   = 2'b10,
    ILLEGAL = 2'b11
  } state_e;

  logic [1:0]    ss_sync_q;
  logic          ss_prev_q;
  logic          ss_p_q;
  logic [1:0]    clr_sync_q;
  logic          clr_prev_q;
  logic          clr_p_q;

  state_e        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          cnt_en_q, cnt_en_d;
  logic          cnt_clr_q, cnt_clr_d;
  logic          running_q, running_d;

  logic [SW-1:0] scan_q, scan_d;
  logic          sel_q, sel_d;
  logic [3:0]    seg_q, seg_d;
  logic [1:0]    an_q, an_d;

  // Two-flop synchronizers followed by a registered rising-edge detector per button.
  always_ff @(posedge Clk or negedge RST_n) begin
    if (!RST_n) begin
      ss_sync_q  <= 2'b00;
      ss_prev_q  <= 1'b0;
      ss_p_q     <= 1'b0;
      clr_sync_q <= 2'b00;
      clr_prev_q <= 1'b0;
      clr_p_q    <= 1'b0;
    end else begin
      ss_sync_q  <= {ss_sync_q[0], btn_ss};
      ss_prev_q  <= ss_sync_q[1];
      ss_p_q     <= ss_sync_q[1] & ~ss_prev_q;
      clr_sync_q <= {clr_sync_q[0], btn_clr};
      clr_prev_q <= clr_sync_q[1];
      clr_p_q    <= clr_sync_q[1] & ~clr_prev_q;
    end
  end

  // Run-control state register with prescaler and registered control outputs.
  always_ff @(posedge Clk or negedge RST_n) begin
    if (!RST_n) begin
      state_q   <= IDLE;
      pre_q     <= '0;
      cnt_en_q  <= 1'b0;
      cnt_clr_q <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      cnt_en_q  <= cnt_en_d;
      cnt_clr_q <= cnt_clr_d;
      running_q <= running_d;
    end
  end

  // Next-state logic; a clear press overrides start/stop, and the prescaler only
  // advances on cycles that stay in RUN so no tick lands on a pause or clear edge.
  always_comb begin
    state_d   = state_q;
    pre_d     = pre_q;
    cnt_en_d  = 1'b0;
    cnt_clr_d = 1'b0;
    if (clr_p_q) begin
      state_d   = IDLE;
      pre_d     = '0;
      cnt_clr_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          pre_d = '0;
          if (ss_p_q) begin
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
        RUN: begin
          if (ss_p_q) begin
            state_d = PAUSE;
          end else if (pre_q == PRE_MAX) begin
            pre_d    = '0;
            cnt_en_d = 1'b1;
          end else begin
            pre_d = pre_q + PRE_ONE;
          end
        end
        PAUSE: begin
          if (ss_p_q) begin
            state_d = RUN;
          end else begin
            state_d = PAUSE;
          end
        end
        default: begin
          state_d = IDLE;
          pre_d   = '0;
        end
      endcase
    end
    running_d = (state_d == RUN);
  end

  // Display scan counter, slot select and registered decoder/anode outputs.
  always_ff @(posedge Clk or negedge RST_n) begin
    if (!RST_n) begin
      scan_q <= '0;
      sel_q  <= 1'b0;
      seg_q  <= 4'h0;
      an_q   <= 2'b11;
    end else begin
      scan_q <= scan_d;
      sel_q  <= sel_d;
      seg_q  <= seg_d;
      an_q   <= an_d;
    end
  end

  // Digit and anode are loaded together at each slot boundary, from the slot sel names.
  always_comb begin
    scan_d = scan_q + SCAN_ONE;
    sel_d  = sel_q;
    seg_d  = seg_q;
    an_d   = an_q;
    if (scan_q == SCAN_MAX) begin
      scan_d = '0;
      sel_d  = ~sel_q;
      if (!sel_q) begin
        seg_d = bus.digits;
        an_d  = 2'b10;
      end else begin
`ifdef STOPWATCH_BLANK_EN
        if (bus.tens == 4'h0) begin
          seg_d = 4'hF;
          an_d  = 2'b11;
        end else begin
          seg_d = bus.tens;
          an_d  = 2'b01;
        end
`else
        seg_d = bus.tens;
        an_d  = 2'b01;
`endif
      end
    end else begin
      scan_d = scan_q + SCAN_ONE;
    end
  end

  assign bus.cnt_en  = cnt_en_q;
  assign bus.cnt_clr = cnt_clr_q;
  assign bus.running = running_q;
  assign bus.seg_bcd = seg_q;
  assign bus.an      = an_q;

endmodule
